// File: rtl/mmeta_done_join.sv
// -----------------------------------------------------------------------------
// mmeta_done_join
//
// Return-path join for the matrix meta-info fork. Every meta-info record that
// is broadcast to the sequential and shuffle modules is recorded here in issue
// order. Each path reports completions strictly in order (oldest outstanding
// entry first). An entry is offered back to the matrix control machine only
// once both paths have completed it. The buffer depth bounds how many meta
// entries may be in flight at once.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   issue_valid_i/_ready_o, issue_i
//                         meta-info issue handshake and payload
//   seq_done_valid_i/_ready_o
//                         sequential path completion handshake
//   shf_done_valid_i/_ready_o
//                         shuffle path completion handshake
//   retire_valid_o/_ready_i, retire_o
//                         retirement handshake and head payload
//   outstanding_o         number of occupied entries
//   idle_o                no entries outstanding
//
// All outputs are functions of registered state only; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module mmeta_done_join #(
    parameter type meta_glb_t = logic,
    parameter int  DEPTH      = 4,
    parameter int  CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  meta_glb_t        issue_i,

    input  logic             seq_done_valid_i,
    output logic             seq_done_ready_o,
    input  logic             shf_done_valid_i,
    output logic             shf_done_ready_o,

    output logic             retire_valid_o,
    input  logic             retire_ready_i,
    output meta_glb_t        retire_o,

    output logic [CNT_W-1:0] outstanding_o,
    output logic             idle_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    meta_glb_t        entry_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    // seq_cnt / shf_cnt count completed entries starting at the head, so both
    // are always <= cnt and the head is finished on a path when its count != 0.
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] shf_cnt_q, shf_cnt_d;

    logic issue_fire;
    logic seq_fire;
    logic shf_fire;
    logic retire_fire;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Net change of a counter with one increment and one decrement source;
    // simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] net_cnt(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + CNT_W'(1);
        end else if (dec && !inc) begin
            nxt = cur - CNT_W'(1);
        end
        return nxt;
    endfunction

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
        logic [PTR_W-1:0] nxt;
        if (cur == LAST_PTR) begin
            nxt = '0;
        end else begin
            nxt = cur + PTR_W'(1);
        end
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake outputs (registered state only)
    // -------------------------------------------------------------------------
    // No pass-through when full: a same-cycle retire does not free a slot for
    // the issue in that cycle, which keeps issue_ready_o free of retire_ready_i.
    assign issue_ready_o    = (cnt_q < DEPTH_C);
    // Completions only for entries issued in an earlier cycle: cnt_q does not
    // yet include an issue firing this cycle.
    assign seq_done_ready_o = (seq_cnt_q < cnt_q);
    assign shf_done_ready_o = (shf_cnt_q < cnt_q);
    assign retire_valid_o   = (cnt_q != '0) && (seq_cnt_q != '0) && (shf_cnt_q != '0);
    assign retire_o         = entry_q[rd_ptr_q];
    assign outstanding_o    = cnt_q;
    assign idle_o           = (cnt_q == '0);

    assign issue_fire  = issue_valid_i    && issue_ready_o;
    assign seq_fire    = seq_done_valid_i && seq_done_ready_o;
    assign shf_fire    = shf_done_valid_i && shf_done_ready_o;
    assign retire_fire = retire_valid_o   && retire_ready_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        if (issue_fire) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (retire_fire) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        // Retiring the head removes one entry from every head-aligned count.
        cnt_d     = net_cnt(cnt_q,     issue_fire, retire_fire);
        seq_cnt_d = net_cnt(seq_cnt_q, seq_fire,   retire_fire);
        shf_cnt_d = net_cnt(shf_cnt_q, shf_fire,   retire_fire);
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of process order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            seq_cnt_q <= '0;
            shf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            seq_cnt_q <= seq_cnt_d;
            shf_cnt_q <= shf_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Payload storage
    // -------------------------------------------------------------------------
    // NOTE: the payload array has no reset; cleared counters make every slot
    // invalid, and retire_o is don't-care while retire_valid_o is low.
    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            entry_q[wr_ptr_q] <= issue_i;
        end
    end

endmodule

// File: tb/tb_mmeta_done_join.sv
// -----------------------------------------------------------------------------
// tb_mmeta_done_join
//
// Cycle-table bench for mmeta_done_join (8-bit payload, DEPTH = 4). Each table
// row holds the inputs driven in one cycle and the control outputs expected in
// that same cycle, before the clock edge. Payloads accepted by the issue port
// go into a scoreboard queue and are popped and compared whenever a row
// expects a retirement to fire. Hand-written sequences cover the held-retire
// stability case and an asynchronous reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_mmeta_done_join;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [7:0] meta_t;

    typedef struct {
        logic             iv;   // issue_valid_i
        meta_t            d;    // issue_i
        logic             sv;   // seq_done_valid_i
        logic             hv;   // shf_done_valid_i
        logic             rr;   // retire_ready_i
        logic             ir;   // expected issue_ready_o
        logic             sr;   // expected seq_done_ready_o
        logic             hr;   // expected shf_done_ready_o
        logic             rv;   // expected retire_valid_o
        logic [CNT_W-1:0] out;  // expected outstanding_o
    } vec_t;

    logic             clk_i;
    logic             rst_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    meta_t            issue_i;
    logic             seq_done_valid_i;
    logic             seq_done_ready_o;
    logic             shf_done_valid_i;
    logic             shf_done_ready_o;
    logic             retire_valid_o;
    logic             retire_ready_i;
    meta_t            retire_o;
    logic [CNT_W-1:0] outstanding_o;
    logic             idle_o;

    int    n_checks;
    int    n_fail;
    meta_t sb_q[$];
    vec_t  tbl[$];
    vec_t  hold[$];
    vec_t  pre_rst[$];

    mmeta_done_join #(
        .meta_glb_t (meta_t),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_i          (issue_i),
        .seq_done_valid_i (seq_done_valid_i),
        .seq_done_ready_o (seq_done_ready_o),
        .shf_done_valid_i (shf_done_valid_i),
        .shf_done_ready_o (shf_done_ready_o),
        .retire_valid_o   (retire_valid_o),
        .retire_ready_i   (retire_ready_i),
        .retire_o         (retire_o),
        .outstanding_o    (outstanding_o),
        .idle_o           (idle_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic iv, input meta_t d, input logic sv, input logic hv, input logic rr,
        input logic ir, input logic sr, input logic hr, input logic rv,
        input logic [CNT_W-1:0] out
    );
        vec_t v;
        v.iv = iv; v.d  = d;  v.sv = sv; v.hv = hv; v.rr  = rr;
        v.ir = ir; v.sr = sr; v.hr = hr; v.rv = rv; v.out = out;
        return v;
    endfunction

    // Packed control view: {issue_rdy, seq_rdy, shf_rdy, retire_vld, outstanding, idle}
    function automatic logic [31:0] ctl_now();
        return 32'({issue_ready_o, seq_done_ready_o, shf_done_ready_o,
                    retire_valid_o, outstanding_o, idle_o});
    endfunction

    // Check this cycle's outputs, drive this cycle's inputs, advance one clock.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] exp_ctl;
        meta_t       exp_d;
        exp_ctl = 32'({v.ir, v.sr, v.hr, v.rv, v.out, (v.out == '0)});
        check({tag, " ctl"}, ctl_now(), exp_ctl);
        if (v.rv && v.rr) begin
            if (sb_q.size() == 0) begin
                check({tag, " retire with empty scoreboard"}, 32'd1, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                check({tag, " retire_o"}, 32'(retire_o), 32'(exp_d));
            end
        end
        issue_valid_i    = v.iv;
        issue_i          = v.d;
        seq_done_valid_i = v.sv;
        shf_done_valid_i = v.hv;
        retire_ready_i   = v.rr;
        if (v.iv && v.ir) sb_q.push_back(v.d);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid_i    = 1'b0;
        issue_i          = '0;
        seq_done_valid_i = 1'b0;
        shf_done_valid_i = 1'b0;
        retire_ready_i   = 1'b0;
    endtask

    // Reset values: issue_ready=1, done readies=0, retire_valid=0, outstanding=0, idle=1
    localparam logic [31:0] RESET_CTL = 32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b1;
        clear_inputs();

        // ---------------- cycle table ----------------
        //            iv  d      sv hv rr   ir sr hr rv out
        // Single entry: issue, both done next cycle, retire the cycle after.
        tbl.push_back(mk(1, 8'hA1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0,  1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0));
        // Fill to DEPTH with no completions; fifth issue refused.
        tbl.push_back(mk(1, 8'hB1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hB2, 0, 0, 0,  1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 8'hB3, 0, 0, 0,  1, 1, 1, 0, 2));
        tbl.push_back(mk(1, 8'hB4, 0, 0, 0,  1, 1, 1, 0, 3));
        tbl.push_back(mk(1, 8'hEE, 0, 0, 0,  0, 1, 1, 0, 4));
        // Full with head complete: retire fires, same-cycle issue refused, accepted next.
        tbl.push_back(mk(0, 8'h00, 1, 1, 0,  0, 1, 1, 0, 4));
        tbl.push_back(mk(1, 8'hB5, 0, 0, 1,  0, 1, 1, 1, 4));
        tbl.push_back(mk(1, 8'hB5, 0, 0, 0,  1, 1, 1, 0, 3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  0, 1, 1, 0, 4));
        // Drain with concurrent completions and retirements.
        tbl.push_back(mk(0, 8'h00, 1, 1, 0,  0, 1, 1, 0, 4));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1,  0, 1, 1, 1, 4));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1,  1, 1, 1, 1, 3));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1,  1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1,  1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0));
        // Seq runs ahead of shf: one retirement, then shf catches up in order.
        tbl.push_back(mk(1, 8'hC1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hC2, 1, 1, 0,  1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 8'hC3, 1, 0, 0,  1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1,  1, 1, 1, 1, 3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0,  1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1,  1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 1, 1, 2));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1,  1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0));

        // ---------------- held retire (retire_ready low for 5 cycles) ----------------
        hold.push_back(mk(1, 8'hD2, 0, 1, 0,  1, 0, 0, 1, 1));
        hold.push_back(mk(1, 8'hD3, 0, 1, 0,  1, 1, 1, 1, 2));
        hold.push_back(mk(1, 8'hD4, 0, 1, 0,  1, 1, 1, 1, 3));
        hold.push_back(mk(1, 8'hDE, 1, 0, 0,  0, 1, 1, 1, 4));
        hold.push_back(mk(0, 8'h00, 1, 0, 0,  0, 1, 1, 1, 4));

        // ---------------- traffic before the mid-stream reset ----------------
        pre_rst.push_back(mk(1, 8'hF1, 0, 0, 0,  1, 0, 0, 0, 0));
        pre_rst.push_back(mk(1, 8'hF2, 1, 0, 0,  1, 1, 1, 0, 1));
        pre_rst.push_back(mk(1, 8'hF3, 0, 1, 0,  1, 1, 1, 0, 2));

        // Reset values are visible while reset is held.
        #12;
        check("reset ctl", ctl_now(), RESET_CTL);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Held retire: head D1 complete, retire_ready low; other ports keep working.
        apply(mk(1, 8'hD1, 0, 0, 0,  1, 0, 0, 0, 0), "hold issue");
        apply(mk(0, 8'h00, 1, 1, 0,  1, 1, 1, 0, 1), "hold done");
        foreach (hold[i]) begin
            check($sformatf("hold%0d retire_o stable", i), 32'(retire_o), 32'h0000_00D1);
            apply(hold[i], $sformatf("hold%0d", i));
        end
        apply(mk(0, 8'h00, 0, 0, 1,  0, 1, 1, 1, 4), "hold release");
        apply(mk(0, 8'h00, 1, 0, 1,  1, 1, 1, 1, 3), "drain0");
        apply(mk(0, 8'h00, 1, 1, 1,  1, 0, 1, 1, 2), "drain1");
        apply(mk(0, 8'h00, 0, 0, 1,  1, 0, 0, 1, 1), "drain2");
        apply(mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0), "drain3");

        // Mid-stream reset with three entries outstanding, partially completed.
        foreach (pre_rst[i]) apply(pre_rst[i], $sformatf("pre_rst%0d", i));
        check("pre-reset ctl", ctl_now(), 32'({1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0}));
        #2;
        rst_i = 1'b1;
        clear_inputs();
        #1;
        check("async reset ctl", ctl_now(), RESET_CTL);
        sb_q.delete();
        @(posedge clk_i);
        #1;
        check("held reset ctl", ctl_now(), RESET_CTL);
        rst_i = 1'b0;

        // Fresh single-entry sequence after reset.
        for (int i = 0; i < 4; i++) apply(tbl[i], $sformatf("post_rst%0d", i));

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
